gpu_cache_fill_arbiter: RTL
===========================

GPU_CACHE_FILL_ARBITER -- requirements
Module: gpu_cache_fill_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; i_nrst  in  1  asynchronous reset, active low.
REQ-002 The block SHALL have these texture-fill ports: requTexL  in  1  left texture fill request; adrTexL  in  17  left 64-bit word address; requTexR  in  1  right request; adrTexR  in  17  right address; doneTexL  out  1  left complete pulse; doneTexR  out  1  right complete pulse.
REQ-003 The block SHALL have these CLUT-fill ports: requClutL  in  1; adrClutL  in  15  CLUT ID; requClutR  in  1; adrClutR  in  15; doneClutL  out  1; doneClutR  out  1.
REQ-004 The block SHALL have these memory ports: memReq  out  1  read request; memAdr  out  17  first word address; memLen  out  3  beats (1 or 4); memAck  in  1  request accepted; memDataValid  in  1  beat valid; memData  in  64  beat data; memDataReady  out  1  beat accepted.
REQ-005 The block SHALL have these cache-write ports: texWrite  out  1; texWrAdr  out  17; texWrData  out  64; clutWrite  out  1; clutWrIdx  out  3; clutWrData  out  32.

Function
REQ-006 The FSM SHALL use the states IDLE, TEX_REQ, TEX_DATA, CLUT_REQ, CLUT_LO, CLUT_HI and DONE.
REQ-007 In IDLE, any pending CLUT request SHALL win over any texture request.
REQ-008 Within a class, L/R arbitration SHALL be round-robin: a 1-bit lastGrant flag updated on each grant, and the side not granted last SHALL win a tie.
REQ-009 Grant SHALL latch the side and address, and memReq SHALL assert the next cycle.
REQ-010 memReq, memAdr and memLen SHALL hold until sampled with memAck=1, and memReq SHALL drop the cycle after.
REQ-011 A texture grant SHALL drive memAdr=adrTex and memLen=1; the beat SHALL be accepted in TEX_DATA (memDataReady=1).
REQ-012 One cycle after the texture beat, texWrite SHALL pulse with texWrAdr=latched address and texWrData=memData; the FSM SHALL then go to DONE.
REQ-013 A CLUT grant SHALL drive memAdr={adrClut,2'b00} and memLen=4.
REQ-014 For each CLUT beat n (0..3): CLUT_LO SHALL accept the beat (memDataReady=1), register it and write the low 32 bits with idx 2n. CLUT_HI SHALL hold memDataReady=0 and write the high 32 bits with idx 2n+1.
REQ-015 After beat 3 HI the FSM SHALL go to DONE; a 2-bit beat counter SHALL wrap to 0.
REQ-016 In DONE, exactly one done* output SHALL pulse for 1 cycle (two when merged); the FSM SHALL then return to IDLE.
REQ-017 A requester SHALL hold requ* until it sees done* and SHALL deassert by the following edge; IDLE SHALL not re-grant a side during its done cycle.
REQ-018 memDataReady SHALL be 0 outside TEX_DATA and CLUT_LO; beats presented then SHALL be stalled, not dropped.
REQ-019 Requests changing while not granted SHALL be ignored until IDLE.
REQ-020 Fill latency SHALL be: texture fill, done at ≥ 5 cycles from request with zero-wait memory; CLUT fill, done at ≥ 12 cycles.

Reset
REQ-021 i_nrst low SHALL immediately force: FSM to IDLE, lastGrant to 0 (L preferred), counter to 0, and every output to 0.
REQ-022 A reset mid-transfer SHALL abandon the transfer without a done pulse; the memory controller is reset by the same i_nrst.

Configuration
REQ-023 With GPU_FILL_MERGE_EN defined, simultaneous same-class L and R requests with equal addresses SHALL be served by one fill and both done signals SHALL pulse together in DONE.
REQ-024 Without GPU_FILL_MERGE_EN, such requests SHALL be served as two sequential fills per round-robin.

Verification
REQ-025 Texture fill: requTexL=1, adrTexL=0x1ABCD, memAck next cycle, beat 0x0123456789ABCDEF -> memAdr=0x1ABCD, memLen=1, texWrite with same addr/data, then one doneTexL pulse.
REQ-026 CLUT fill: requClutR=1, adrClutR=0x0040, four beats -> memAdr=0x00100, memLen=4, eight clutWrite with idx 0..7 alternating low/high halves, then one doneClutR pulse.
REQ-027 Priority/round-robin: requTexL, requClutL, requClutR all asserted at once -> order ClutL, ClutR, TexL.
REQ-028 Merge: requTexL=requTexR=1, both addr 0x00010 -> with GPU_FILL_MERGE_EN: one memReq, doneTexL and doneTexR in the same cycle; without it: two memReq.
REQ-029 Back-to-back CLUT beats with memDataValid held 1 -> memDataReady toggles 1,0 per beat; no beat lost; idx sequence 0..7 intact.
REQ-030 Reset asserted during CLUT beat 2 -> all outputs 0 at once; no done pulse; next request served normally from IDLE.

Source files
------------

// File: rtl/gpu_cache_fill_arbiter.sv
// gpu_cache_fill_arbiter: arbitrates L/R texture and CLUT fills onto one memory read port.
// Optional GPU_FILL_MERGE_EN merges equal-address same-class L/R requests into one fill.
module gpu_cache_fill_arbiter (
    input  logic        clk,
    input  logic        i_nrst,
    input  logic        requTexL,
    input  logic [16:0] adrTexL,
    input  logic        requTexR,
    input  logic [16:0] adrTexR,
    output logic        doneTexL,
    output logic        doneTexR,
    input  logic        requClutL,
    input  logic [14:0] adrClutL,
    input  logic        requClutR,
    input  logic [14:0] adrClutR,
    output logic        doneClutL,
    output logic        doneClutR,
    output logic        memReq,
    output logic [16:0] memAdr,
    output logic [2:0]  memLen,
    input  logic        memAck,
    input  logic        memDataValid,
    input  logic [63:0] memData,
    output logic        memDataReady,
    output logic        texWrite,
    output logic [16:0] texWrAdr,
    output logic [63:0] texWrData,
    output logic        clutWrite,
    output logic [2:0]  clutWrIdx,
    output logic [31:0] clutWrData
);
    typedef enum logic [2:0] {IDLE, TEX_REQ, TEX_DATA, CLUT_REQ, CLUT_LO, CLUT_HI, DONE} state_t;
    state_t r_state, w_state_nxt;
    logic        r_last_grant, r_side, r_is_clut, r_merge;
    logic [1:0]  r_cnt;
    logic [31:0] r_beat_hi;
    logic        r_mem_req;
    logic [16:0] r_mem_adr;
    logic [2:0]  r_mem_len;
    logic        r_tex_write;
    logic [16:0] r_tex_wr_adr;
    logic [63:0] r_tex_wr_data;
    logic        r_clut_write;
    logic [2:0]  r_clut_wr_idx;
    logic [31:0] r_clut_wr_data;
    logic        r_done_tl, r_done_tr, r_done_cl, r_done_cr;
    logic        w_tl, w_tr, w_cl, w_cr, w_clut, w_l, w_r, w_side, w_merge;
    logic [16:0] w_adr;

    // A side whose done pulse is showing still holds its request for this cycle.
    assign w_tl   = requTexL  & ~r_done_tl;
    assign w_tr   = requTexR  & ~r_done_tr;
    assign w_cl   = requClutL & ~r_done_cl;
    assign w_cr   = requClutR & ~r_done_cr;
    assign w_clut = w_cl | w_cr;
    assign w_l    = w_clut ? w_cl : w_tl;
    assign w_r    = w_clut ? w_cr : w_tr;
    assign w_side = (w_l & w_r) ? r_last_grant : w_r;
`ifdef GPU_FILL_MERGE_EN
    assign w_merge = w_l & w_r & (w_clut ? (adrClutL == adrClutR) : (adrTexL == adrTexR));
`else
    assign w_merge = 1'b0;
`endif
    assign w_adr = w_clut ? {(w_side ? adrClutR : adrClutL), 2'b00} : (w_side ? adrTexR : adrTexL);

    assign memReq       = r_mem_req;
    assign memAdr       = r_mem_adr;
    assign memLen       = r_mem_len;
    assign memDataReady = (r_state == TEX_DATA) || (r_state == CLUT_LO);
    assign texWrite     = r_tex_write;
    assign texWrAdr     = r_tex_wr_adr;
    assign texWrData    = r_tex_wr_data;
    assign clutWrite    = r_clut_write;
    assign clutWrIdx    = r_clut_wr_idx;
    assign clutWrData   = r_clut_wr_data;
    assign doneTexL     = r_done_tl;
    assign doneTexR     = r_done_tr;
    assign doneClutL    = r_done_cl;
    assign doneClutR    = r_done_cr;

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_l | w_r) w_state_nxt = w_clut ? CLUT_REQ : TEX_REQ;
            TEX_REQ:  if (memAck) w_state_nxt = TEX_DATA;
            TEX_DATA: if (memDataValid) w_state_nxt = DONE;
            CLUT_REQ: if (memAck) w_state_nxt = CLUT_LO;
            CLUT_LO:  if (memDataValid) w_state_nxt = CLUT_HI;
            CLUT_HI:  w_state_nxt = (r_cnt == 2'd3) ? DONE : CLUT_LO;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_last_grant   <= 1'b0;
            r_side         <= 1'b0;
            r_is_clut      <= 1'b0;
            r_merge        <= 1'b0;
            r_cnt          <= 2'd0;
            r_beat_hi      <= 32'd0;
            r_mem_req      <= 1'b0;
            r_mem_adr      <= 17'd0;
            r_mem_len      <= 3'd0;
            r_tex_write    <= 1'b0;
            r_tex_wr_adr   <= 17'd0;
            r_tex_wr_data  <= 64'd0;
            r_clut_write   <= 1'b0;
            r_clut_wr_idx  <= 3'd0;
            r_clut_wr_data <= 32'd0;
            r_done_tl      <= 1'b0;
            r_done_tr      <= 1'b0;
            r_done_cl      <= 1'b0;
            r_done_cr      <= 1'b0;
        end else begin
            r_tex_write  <= 1'b0;
            r_clut_write <= 1'b0;
            r_done_tl    <= 1'b0;
            r_done_tr    <= 1'b0;
            r_done_cl    <= 1'b0;
            r_done_cr    <= 1'b0;
            case (r_state)
                IDLE: if (w_l | w_r) begin
                    r_is_clut <= w_clut;
                    r_side    <= w_side;
                    r_merge   <= w_merge;
                    if (!w_merge) r_last_grant <= ~w_side;
                    r_mem_req <= 1'b1;
                    r_mem_adr <= w_adr;
                    r_mem_len <= w_clut ? 3'd4 : 3'd1;
                    if (!w_clut) r_tex_wr_adr <= w_adr;
                end
                TEX_REQ, CLUT_REQ: if (memAck) r_mem_req <= 1'b0;
                TEX_DATA: if (memDataValid) begin
                    r_tex_write   <= 1'b1;
                    r_tex_wr_data <= memData;
                end
                CLUT_LO: if (memDataValid) begin
                    r_beat_hi      <= memData[63:32];
                    r_clut_write   <= 1'b1;
                    r_clut_wr_idx  <= {r_cnt, 1'b0};
                    r_clut_wr_data <= memData[31:0];
                end
                CLUT_HI: begin
                    r_clut_write   <= 1'b1;
                    r_clut_wr_idx  <= {r_cnt, 1'b1};
                    r_clut_wr_data <= r_beat_hi;
                    r_cnt          <= r_cnt + 2'd1;
                end
                DONE: begin
                    r_done_tl <= ~r_is_clut & (~r_side | r_merge);
                    r_done_tr <= ~r_is_clut & ( r_side | r_merge);
                    r_done_cl <=  r_is_clut & (~r_side | r_merge);
                    r_done_cr <=  r_is_clut & ( r_side | r_merge);
                end
                default: ;
            endcase
        end
    end
endmodule
